// File: rtl/rpc_request_queue.sv
// Slot-addressed request buffer: push stores a payload in a free slot and returns its ID, pop by ID reads and frees it.
// Optional `RQ_ALLOC_CHECK_EN adds an allocated-slot bitmap that rejects pops of slots not currently held.
module rpc_request_queue #(
  parameter int DATA_WIDTH = 512,
  parameter int LSIZE      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_en_in,
  input  logic [DATA_WIDTH-1:0] push_data_in,
  output logic [LSIZE-1:0]      push_slot_id_out,
  output logic                  push_done_out,
  input  logic                  pop_en_in,
  input  logic [LSIZE-1:0]      pop_slot_id_in,
  output logic [DATA_WIDTH-1:0] pop_data_out,
  input  logic                  initialize,
  output logic                  initialized,
  output logic                  error
);
  localparam int N = 1 << LSIZE;
  localparam logic [LSIZE:0]   CNT_N = (LSIZE+1)'(N);
  localparam logic [LSIZE-1:0] LAST  = LSIZE'(N-1);

  typedef enum logic [1:0] {IDLE, INIT, READY} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] ram [N];
  logic [LSIZE-1:0]      fl  [N];
  logic [LSIZE-1:0]      rptr, wptr, head, init_cnt, fl_wdata;
  logic [LSIZE:0]        count;
  logic                  init_wr, push_ok, push_bad, pop_ok, pop_bad, fl_we, alloc_hit;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (initialize) state_nxt = INIT;
      INIT:    if (init_cnt == LAST) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    initialized = (state == READY);
    init_wr     = (state == INIT);
  end

  always_ff @(posedge clk) begin
    if (reset || !init_wr) init_cnt <= '0;
    else                   init_cnt <= init_cnt + 1'b1;
  end

`ifdef RQ_ALLOC_CHECK_EN
  logic [N-1:0] alloc;
  assign alloc_hit = alloc[pop_slot_id_in];

  always_ff @(posedge clk) begin
    if (reset) alloc <= '0;
    else begin
      if (pop_ok)  alloc[pop_slot_id_in] <= 1'b0;
      if (push_ok) alloc[head]           <= 1'b1;
    end
  end
`else
  assign alloc_hit = 1'b1;
`endif

  // Push and pop both decide on the registered count, so a slot freed this cycle is only pushable next cycle.
  assign head     = fl[rptr];
  assign push_ok  = push_en_in && initialized && (count != '0);
  assign push_bad = push_en_in && !push_ok;
  // Outside Ready the free list belongs to the init sequence, so pops there never enqueue.
  assign pop_ok   = pop_en_in && initialized && (count != CNT_N) && alloc_hit;
  assign pop_bad  = pop_en_in && ((count == CNT_N) || !alloc_hit);
  assign fl_we    = init_wr || pop_ok;
  assign fl_wdata = init_wr ? init_cnt : pop_slot_id_in;

  always_ff @(posedge clk) begin
    if (!reset && fl_we) fl[wptr] <= fl_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (fl_we)   wptr <= wptr + 1'b1;
      if (push_ok) rptr <= rptr + 1'b1;
      count <= count + (LSIZE+1)'(fl_we) - (LSIZE+1)'(push_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) ram[head] <= push_data_in;
  end

  // The read sees the pre-edge RAM, giving read-before-write on a same-slot push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      push_done_out    <= 1'b0;
      push_slot_id_out <= '0;
      pop_data_out     <= '0;
      error            <= 1'b0;
    end else begin
      push_done_out <= push_ok;
      if (push_ok)   push_slot_id_out <= head;
      if (pop_en_in) pop_data_out     <= ram[pop_slot_id_in];
      error <= error | push_bad | pop_bad;
    end
  end
endmodule

// File: tb/tb_rpc_request_queue.sv
// Scoreboard bench for rpc_request_queue (N=4): the driver queues expected slot IDs / pop data, a negedge monitor compares.
module tb_rpc_request_queue;
  localparam int DW = 32;
  localparam int LS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push_en_in = 1'b0;
  logic [DW-1:0] push_data_in = '0;
  logic          pop_en_in = 1'b0;
  logic [LS-1:0] pop_slot_id_in = '0;
  logic          initialize = 1'b0;
  logic [LS-1:0] push_slot_id_out;
  logic          push_done_out;
  logic [DW-1:0] pop_data_out;
  logic          initialized;
  logic          error;

  rpc_request_queue #(.DATA_WIDTH(DW), .LSIZE(LS)) dut (
    .clk(clk), .reset(reset),
    .push_en_in(push_en_in), .push_data_in(push_data_in),
    .push_slot_id_out(push_slot_id_out), .push_done_out(push_done_out),
    .pop_en_in(pop_en_in), .pop_slot_id_in(pop_slot_id_in), .pop_data_out(pop_data_out),
    .initialize(initialize), .initialized(initialized), .error(error)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [DW-1:0] mem [4];
  int            exp_push_q [$];
  logic [DW-1:0] exp_pop_q [$];
  logic          pop_d = 1'b0;
`ifdef RQ_ALLOC_CHECK_EN
  localparam logic ALLOC_ERR = 1'b1;
`else
  localparam logic ALLOC_ERR = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) pop_d <= pop_en_in && !reset;

  always @(negedge clk) begin
    if (push_done_out) begin
      if (exp_push_q.size() == 0) check("push_done_unexpected", 64'(push_done_out), 64'd0);
      else check("push_slot_id", 64'(push_slot_id_out), 64'(exp_push_q.pop_front()));
    end
    if (pop_d) begin
      if (exp_pop_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL pop_unexpected: got data %0h with no pop expected", pop_data_out);
      end else check("pop_data", 64'(pop_data_out), 64'(exp_pop_q.pop_front()));
    end
  end

  task automatic next();
    @(posedge clk); #1;
  endtask

  // Applies one cycle of stimulus; es is the expected slot for an accepted push, -1 for a dropped one.
  task automatic drive(input logic pe, input logic [DW-1:0] pd, input int es,
                       input logic oe, input logic [LS-1:0] os);
    if (oe) exp_pop_q.push_back(mem[os]);
    if (es >= 0) begin
      exp_push_q.push_back(es);
      mem[LS'(es)] = pd;
    end
    push_en_in = pe; push_data_in = pd; pop_en_in = oe; pop_slot_id_in = os;
    next();
    push_en_in = 1'b0; pop_en_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    foreach (mem[i]) mem[i] = '0;
    reset = 1'b1; next(); next(); reset = 1'b0;
    @(negedge clk);
    check("rst_push_done", 64'(push_done_out), 0);
    check("rst_slot_id", 64'(push_slot_id_out), 0);
    check("rst_pop_data", 64'(pop_data_out), 0);
    check("rst_initialized", 64'(initialized), 0);
    check("rst_error", 64'(error), 0);
    next();

    // push before init is dropped and flags error
    drive(1'b1, 32'h0BAD, -1, 1'b0, 2'd0);
    @(negedge clk); check("early_push_error", 64'(error), 1); next();
    reset = 1'b1; next(); reset = 1'b0;
    @(negedge clk); check("error_cleared", 64'(error), 0); next();

    // init pulse in cycle 0 -> initialized from cycle 5
    initialize = 1'b1; next(); initialize = 1'b0;
    next(); next(); next();
    @(negedge clk); check("init_c4", 64'(initialized), 0); next();
    @(negedge clk); check("init_c5", 64'(initialized), 1); check("init_error", 64'(error), 0); next();

    drive(1'b1, 32'h0000_00A5, 0, 1'b0, 2'd0);
    drive(1'b1, 32'h1111_0001, 1, 1'b0, 2'd0);
    drive(1'b1, 32'h2222_0002, 2, 1'b0, 2'd0);
    drive(1'b1, 32'h3333_0003, 3, 1'b0, 2'd0);
    drive(1'b1, 32'h5555_5555, -1, 1'b0, 2'd0);
    @(negedge clk); check("overflow_error", 64'(error), 1); next();

    // recycling, simultaneous push/pop, read-before-write, push-to-pop next cycle
    drive(1'b0, '0, -1, 1'b1, 2'd2);
    drive(1'b1, 32'hEEEE_000E, 2, 1'b0, 2'd0);
    drive(1'b0, '0, -1, 1'b1, 2'd0);
    drive(1'b1, 32'hFFFF_000F, 0, 1'b1, 2'd1);
    drive(1'b1, 32'h6666_0006, 1, 1'b1, 2'd1);
    drive(1'b0, '0, -1, 1'b1, 2'd1);
    @(negedge clk); check("error_sticky", 64'(error), 1); next();

    // reset in cycle 2 of Init aborts it
    reset = 1'b1; next(); reset = 1'b0;
    drive(1'b1, 32'h77, -1, 1'b0, 2'd0);
    @(negedge clk); check("pre_midinit_error", 64'(error), 1); next();
    initialize = 1'b1; next(); initialize = 1'b0;
    next();
    reset = 1'b1; next(); reset = 1'b0;
    @(negedge clk);
    check("midinit_initialized", 64'(initialized), 0);
    check("midinit_error", 64'(error), 0);
    repeat (6) next();
    @(negedge clk); check("midinit_stays_idle", 64'(initialized), 0); next();
    initialize = 1'b1; next(); initialize = 1'b0;
    next(); next(); next();
    @(negedge clk); check("reinit_c4", 64'(initialized), 0); next();
    @(negedge clk); check("reinit_c5", 64'(initialized), 1); next();

    // pop of a never-pushed slot: only an error with the allocation check
    drive(1'b1, 32'h4848_0048, 0, 1'b0, 2'd0);
    drive(1'b0, '0, -1, 1'b1, 2'd2);
    @(negedge clk); check("unalloc_pop_error", 64'(error), 64'(ALLOC_ERR)); next();

    // pop while full errors and leaves the free list intact; RAM survives reset
    reset = 1'b1; next(); reset = 1'b0;
    initialize = 1'b1; next(); initialize = 1'b0;
    repeat (4) next();
    @(negedge clk); check("full_init", 64'(initialized), 1); next();
    drive(1'b0, '0, -1, 1'b1, 2'd1);
    @(negedge clk); check("full_pop_error", 64'(error), 1); next();
    drive(1'b1, 32'h9000_0000, 0, 1'b0, 2'd0);
    drive(1'b1, 32'h9000_0001, 1, 1'b0, 2'd0);
    drive(1'b1, 32'h9000_0002, 2, 1'b0, 2'd0);
    drive(1'b1, 32'h9000_0003, 3, 1'b0, 2'd0);
    drive(1'b1, 32'h9000_0004, -1, 1'b0, 2'd0);
    drive(1'b0, '0, -1, 1'b1, 2'd3);
    next(); next();
    check("push_q_drained", 64'(exp_push_q.size()), 0);
    check("pop_q_drained", 64'(exp_pop_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
